// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-channel cacheline arbiter in front of a single memory port.
// One transaction is in flight at a time. The state machine walks
// IDLE -> BUSY -> DONE -> IDLE.
// Optional feature: define MEM_ARB_RR_EN for round-robin selection.
// Without it, selection is fixed priority (lowest index wins) and no pointer register exists.
//
// Handshake: a channel's ch_read/ch_write is a level-held valid. It stays up until
// that channel's ch_resp bit pulses for one cycle, which marks completion.
// On the memory side, mem_read/mem_write is a level-held valid that stays up
// until mem_resp is seen high at a rising edge.
module mem_arbiter_n #(
  parameter int NUM_CH = 3,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_resp,
  // Debug view of the FSM: 0 = IDLE, 1 = BUSY, 2 = DONE
  output logic [1:0]               state_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [NUM_CH-1:0]   req;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;

  // Read+write on the same channel counts as a write later; here it is just "requesting".
  assign req = ch_read | ch_write;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0]    last_q, last_d;

  // Round-robin pick: scan starting one past the last granted channel.
  always_comb begin
    int cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'({1'b0, last_q}) + k) % NUM_CH;
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  // Pointer moves only when a grant is actually taken in IDLE.
  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && grant_vld) begin
      last_d = grant_idx;
    end
  end

  // Pointer register; resets so that channel 0 is searched first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= IDX_W'(NUM_CH - 1);
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority pick: scan downwards so the lowest requesting index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end
`endif

  // Next state and transaction capture. Channel inputs are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_BUSY;
          addr_d  = ch_address[grant_idx*ADDR_W +: ADDR_W];
          wdata_d = ch_wdata[grant_idx*LINE_W +: LINE_W];
          wr_d    = ch_write[grant_idx];
          idx_d   = grant_idx;
        end
      end
      ST_BUSY: begin
        if (mem_resp) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched transaction registers. Reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
    end
  end

  // Memory side is driven purely from the latched registers.
  assign mem_read    = (state_q == ST_BUSY) && !wr_q;
  assign mem_write   = (state_q == ST_BUSY) && wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

  // Completion is combinational in the cycle mem_resp arrives; rdata is a plain broadcast.
  assign ch_resp  = (state_q == ST_BUSY && mem_resp) ? (NUM_CH'(1) << idx_q) : '0;
  assign ch_rdata = mem_rdata;
  assign state_o  = state_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n. A model of the arbitration rule predicts which channel
// is granted and pushes the expected transaction. Monitors on the memory side and
// the response side pop and compare on their own.
`timescale 1ns/1ps
module tb_mem_arbiter_n;
  localparam int NUM_CH = 3;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [7:0]        ch;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [LINE_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_address;
  logic [LINE_W-1:0]        mem_wdata;
  logic [LINE_W-1:0]        mem_rdata;
  logic                     mem_resp;
  logic [1:0]               state_o;

  mem_arbiter_n #(.NUM_CH(NUM_CH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .ch_resp(ch_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  txn_t exp_q[$];
  int   resp_q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   abort  = 0;
  bit   resp_hold = 0;
  int   spur_mode = 0;   // 0 off, 1 every free cycle, 2 occasional

  // Reference model: pending requests per channel and the last granted channel.
  bit                p_rd[NUM_CH];
  bit                p_wr[NUM_CH];
  logic [ADDR_W-1:0] p_addr[NUM_CH];
  logic [LINE_W-1:0] p_wdata[NUM_CH];
  int                model_last = NUM_CH - 1;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic int model_pick();
    int pick;
    pick = -1;
`ifdef MEM_ARB_RR_EN
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (model_last + k) % NUM_CH;
      if (pick < 0 && (p_rd[c] || p_wr[c])) pick = c;
    end
`else
    for (int c = 0; c < NUM_CH; c++) begin
      if (pick < 0 && (p_rd[c] || p_wr[c])) pick = c;
    end
`endif
    return pick;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_read[c]                    = p_rd[c];
      ch_write[c]                   = p_wr[c];
      ch_address[c*ADDR_W +: ADDR_W] = p_addr[c];
      ch_wdata[c*LINE_W +: LINE_W]   = p_wdata[c];
    end
  endtask

  task automatic clear_all();
    for (int c = 0; c < NUM_CH; c++) begin
      p_rd[c] = 1'b0;
      p_wr[c] = 1'b0;
    end
  endtask

  task automatic rand_chan(input int c);
    int op;
    op = $urandom_range(0, 2);
    p_rd[c]    = (op != 1);
    p_wr[c]    = (op != 0);
    p_addr[c]  = $urandom();
    p_wdata[c] = rand_line();
  endtask

  task automatic predict_push(output int win);
    txn_t t;
    win = model_pick();
    if (win >= 0) begin
      t.ch    = 8'(win);
      t.wr    = p_wr[win];
      t.addr  = p_addr[win];
      t.wdata = p_wdata[win];
      exp_q.push_back(t);
      model_last = win;
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (mem_read || mem_write) begin
        ok = 1'b1;
        break;
      end
    end
    chk("grant_timeout", LINE_W'(ok), LINE_W'(1));
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!(mem_read || mem_write)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", LINE_W'(ok), LINE_W'(1));
    if (ok) chk("done_state", LINE_W'(state_o), LINE_W'(ST_DONE));
  endtask

  // Issue the current pending set, follow the predicted winner to completion.
  task automatic one_grant(input bit early_drop);
    int win;
    bit ok;
    drive_inputs();
    predict_push(win);
    if (win < 0) return;
    wait_busy(ok);
    if (!ok) begin abort = 1; return; end
    // Scramble the winner's live inputs; the memory side must not follow them.
    p_addr[win]  = $urandom();
    p_wdata[win] = rand_line();
    if (early_drop) begin
      p_rd[win] = 1'b0;
      p_wr[win] = 1'b0;
    end
    drive_inputs();
    wait_done(ok);
    if (!ok) begin abort = 1; return; end
    p_rd[win] = 1'b0;
    p_wr[win] = 1'b0;
    drive_inputs();
  endtask

  task automatic enter_reset();
    reset_n = 1'b0;
    exp_q.delete();
    resp_q.delete();
    model_last = NUM_CH - 1;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int lat;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    lat = $urandom_range(0, 3);
    forever begin
      @(posedge clk); #1;
      if (mem_resp) begin
        mem_resp = 1'b0;
      end else if (mem_read || mem_write) begin
        if (!resp_hold) begin
          if (lat == 0) begin
            mem_resp = 1'b1;
            lat = $urandom_range(0, 3);
          end else begin
            lat--;
          end
        end
      end else if (spur_mode == 1 || (spur_mode == 2 && $urandom_range(0, 7) == 0)) begin
        mem_resp = 1'b1;
      end
      mem_rdata = rand_line();
    end
  end

  // ---------------- memory-side monitor ----------------
  initial begin
    bit   prev_busy;
    bit   seen_one;
    bit   busy;
    int   gap;
    txn_t cur;
    prev_busy = 0; seen_one = 0; gap = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_busy = 0; seen_one = 0; gap = 0;
      end else begin
        busy = mem_read || mem_write;
        if (busy && !prev_busy) begin
          if (seen_one) chk("grant_gap", LINE_W'(gap >= 1), LINE_W'(1));
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_grant: got addr %0h expected no grant", mem_address);
          end else begin
            cur = exp_q.pop_front();
            resp_q.push_back(int'(cur.ch));
          end
        end
        if (busy) begin
          chk("mem_op", LINE_W'({mem_write, mem_read}), cur.wr ? LINE_W'(2'b10) : LINE_W'(2'b01));
          chk("mem_address", LINE_W'(mem_address), LINE_W'(cur.addr));
          chk("mem_wdata", mem_wdata, cur.wdata);
          gap = 0;
          seen_one = 1;
        end else begin
          gap++;
        end
        prev_busy = busy;
      end
    end
  end

  // ---------------- response-side monitor ----------------
  initial begin
    bit exp_resp;
    int c;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("rdata_pass", ch_rdata, mem_rdata);
        exp_resp = mem_resp && (mem_read || mem_write);
        if (exp_resp) begin
          if (resp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL resp_no_txn: got ch_resp %0h expected a tracked transaction", ch_resp);
          end else begin
            c = resp_q.pop_front();
            chk("ch_resp", LINE_W'(ch_resp), LINE_W'(NUM_CH'(1) << c));
          end
        end else if (ch_resp != '0) begin
          checks++; fails++;
          $display("FAIL ch_resp_spurious: got %0h expected 0", ch_resp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int win;
    bit ok;
    reset_n    = 1'b0;
    ch_read    = '0;
    ch_write   = '0;
    ch_address = '0;
    ch_wdata   = '0;
    for (int c = 0; c < NUM_CH; c++) rand_chan(c);
    drive_inputs();

    // Reset holds everything quiet even with every channel requesting.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_read", LINE_W'(mem_read), LINE_W'(0));
    chk("rst_mem_write", LINE_W'(mem_write), LINE_W'(0));
    chk("rst_ch_resp", LINE_W'(ch_resp), LINE_W'(0));
    chk("rst_state", LINE_W'(state_o), LINE_W'(ST_IDLE));
    chk("rst_mem_address", LINE_W'(mem_address), LINE_W'(0));
    chk("rst_mem_wdata", mem_wdata, LINE_W'(0));

    // Single read from channel 1 at 0x1000.
    clear_all();
    p_rd[1] = 1'b1; p_addr[1] = 32'h0000_1000; p_wdata[1] = rand_line();
    drive_inputs();
    reset_n = 1'b1;
    one_grant(1'b0);

    // Read+write on channel 1 is a write.
    if (!abort) begin
      p_rd[1] = 1'b1; p_wr[1] = 1'b1; p_addr[1] = $urandom();
      p_wdata[1] = {(LINE_W/8){8'hA5}};
      one_grant(1'b0);
    end

    // Channel 2 drops its read right after the grant.
    if (!abort) begin
      p_rd[2] = 1'b1; p_addr[2] = $urandom(); p_wdata[2] = rand_line();
      one_grant(1'b1);
    end

    // Reset while BUSY: memory side drops at once, no completion; ch0 wins after release.
    if (!abort) begin
      resp_hold = 1'b1;
      p_rd[2] = 1'b1; p_addr[2] = $urandom();
      drive_inputs();
      predict_push(win);
      wait_busy(ok);
      if (!ok) abort = 1;
    end
    if (!abort) begin
      @(posedge clk); #1;
      chk("pre_reset_busy", LINE_W'(mem_read), LINE_W'(1));
      #2;
      enter_reset();
      #1;
      chk("async_rst_mem_read", LINE_W'(mem_read), LINE_W'(0));
      chk("async_rst_ch_resp", LINE_W'(ch_resp), LINE_W'(0));
      chk("async_rst_state", LINE_W'(state_o), LINE_W'(ST_IDLE));
      resp_hold = 1'b0;
      clear_all();
      rand_chan(0); rand_chan(1);
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      one_grant(1'b0);
      if (!abort) one_grant(1'b0);
    end

    // Channels 0 and 2 request continuously from reset.
    if (!abort) begin
      @(posedge clk); #1;
      enter_reset();
      clear_all();
      p_rd[0] = 1'b1; p_addr[0] = $urandom(); p_wdata[0] = rand_line();
      p_rd[2] = 1'b1; p_addr[2] = $urandom(); p_wdata[2] = rand_line();
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4 && !abort; i++) begin
        predict_push(win);
        wait_busy(ok);
        if (ok) wait_done(ok);
        if (!ok) abort = 1;
      end
      clear_all();
      drive_inputs();
    end

    // mem_resp with nobody requesting is ignored.
    if (!abort) begin
      repeat (3) @(posedge clk);
      #1;
      spur_mode = 1;
      repeat (12) begin
        @(negedge clk);
        chk("spur_state", LINE_W'(state_o), LINE_W'(ST_IDLE));
        chk("spur_ch_resp", LINE_W'(ch_resp), LINE_W'(0));
      end
      @(posedge clk); #1;
      spur_mode = 2;
    end

    // Randomized traffic: losers keep requesting, new requests arrive at random.
    for (int r = 0; r < 150 && !abort; r++) begin
      bit any;
      any = 1'b0;
      for (int c = 0; c < NUM_CH; c++) any |= (p_rd[c] || p_wr[c]);
      if (!any && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (!(p_rd[c] || p_wr[c]) && $urandom_range(0, 1) == 1) rand_chan(c);
      end
      any = 1'b0;
      for (int c = 0; c < NUM_CH; c++) any |= (p_rd[c] || p_wr[c]);
      if (!any) rand_chan($urandom_range(0, NUM_CH - 1));
      one_grant(1'($urandom_range(0, 1)));
    end

    // Drain what is still pending, then make sure nothing is left over.
    spur_mode = 0;
    for (int r = 0; r < NUM_CH && !abort; r++) one_grant(1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("queues_drained", LINE_W'(exp_q.size() + resp_q.size()), LINE_W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of requester channels (legal 2..8).
REQ-002 SHALL have parameter LINE_W, default 256, cacheline width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ch_read  input  NUM_CH  per-channel line read request.
REQ-007 SHALL have port ch_write  input  NUM_CH  per-channel line write request.
REQ-008 SHALL have port ch_address  input  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port ch_wdata  input  NUM_CH*LINE_W  per-channel write line, packed the same way.
REQ-010 SHALL have port ch_rdata  output  LINE_W  read line, broadcast to all channels.
REQ-011 SHALL have port ch_resp  output  NUM_CH  one-hot completion pulse.
REQ-012 SHALL have ports mem_read and mem_write  output  1 each  lower-level requests.
REQ-013 SHALL have ports mem_address (output, ADDR_W) and mem_wdata (output, LINE_W).
REQ-014 SHALL have ports mem_rdata (input, LINE_W) and mem_resp (input, 1).

Function
REQ-015 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-016 In IDLE with any ch_read|ch_write bit set, SHALL select one channel, latch its address, wdata, op and index, and go to BUSY on the next edge.
REQ-017 SHALL treat a channel raising both read and write as a write.
REQ-018 In BUSY, SHALL drive mem_read/mem_write (exactly one high), mem_address and mem_wdata from the latched registers only, never from live channel inputs.
REQ-019 In BUSY with mem_resp=1, SHALL assert ch_resp[granted] combinationally in the same cycle, pass mem_rdata onto ch_rdata, and go to DONE.
REQ-020 In DONE, SHALL hold mem_read=mem_write=0 and all ch_resp=0 for exactly one cycle, then return to IDLE; this gives the requester one cycle to drop its request.
REQ-021 SHALL complete a latched transaction, including the ch_resp pulse, even if the granted requester deasserts mid-transaction.
REQ-022 Outside BUSY with mem_resp, SHALL drive ch_resp to all zeros and ch_rdata to mem_rdata unqualified.
REQ-023 SHALL ignore mem_resp in IDLE and DONE.
REQ-024 Minimum request-to-resp latency SHALL be 1 (grant edge) + memory latency; back-to-back grants are separated by at least the one DONE cycle.

Reset
REQ-025 On reset_n=0, SHALL immediately force state=IDLE, mem_read=0, mem_write=0, ch_resp=0, latched registers=0 and the round-robin pointer=NUM_CH-1, without waiting for a clock edge.
REQ-026 A reset asserted during BUSY SHALL abandon the transaction with no ch_resp pulse; the first post-reset grant SHALL go to channel 0 if it is requesting.

Configuration
REQ-027 With MEM_ARB_RR_EN defined, selection SHALL be round-robin: search starts at (last_grant+1) mod NUM_CH, and last_grant updates on each grant.
REQ-028 Without MEM_ARB_RR_EN, selection SHALL be fixed priority (lowest index wins), and the pointer register SHALL not be implemented.

Verification
REQ-029 Single read: ch_read=3'b010, ch1 address 0x0000_1000, mem_resp two cycles after mem_read -> mem_address=0x1000, ch_resp=3'b010 pulsed once, ch_rdata=mem_rdata in that cycle.
REQ-030 Contention, RR: ch0 and ch2 request continuously from reset -> grant order ch0, ch2, ch0, ch2, each separated by one DONE cycle; without the macro -> ch0 every time.
REQ-031 Write precedence: ch1 with read=write=1, wdata=0xA5-repeated -> mem_write=1, mem_read=0, mem_wdata=0xA5..A5.
REQ-032 Request drop: ch2 deasserts read one cycle after grant -> mem_read stays high until mem_resp, and ch_resp[2] still pulses.
REQ-033 Reset mid-BUSY: reset_n=0 while mem_read=1 -> mem_read=0 asynchronously, no ch_resp; after release with ch0 and ch1 requesting -> ch0 granted first.
REQ-034 Spurious resp: mem_resp=1 in IDLE -> ch_resp stays 0 and the state remains IDLE.
